// File: rtl/source_pump_sequencer.sv
// Source inlet dispense sequencer: opens the inlet valve, runs a three-valve
// peristaltic pump for a requested number of strokes, then closes the inlet.
// Optional feature macro: PUMP_REVERSE_EN adds a 'dir' input that runs the
// six-phase pump sequence in reverse when sampled high on an accepted start.
module source_pump_sequencer #(
    parameter int unsigned PHASE_TICKS  = 4,
    parameter int unsigned SETTLE_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
`ifdef PUMP_REVERSE_EN
    input  logic       dir,
`endif
    input  logic [7:0] strokes,
    output logic       inlet_valve,
    output logic [2:0] pump_valve,
    output logic       busy,
    output logic       done,
    output logic [7:0] stroke_cnt
);

    typedef enum logic [1:0] {IDLE, OPEN, PUMP, CLOSE} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_TICKS - 1);
    localparam logic [7:0] PHASE_LAST  = 8'(PHASE_TICKS - 1);

    state_t     state;
    logic [7:0] tick;
    logic [2:0] phase;
    logic [7:0] target;
    logic [7:0] cnt_next;
    logic       rev;
`ifdef PUMP_REVERSE_EN
    logic       dir_q;
    assign rev = dir_q;
`else
    assign rev = 1'b0;
`endif

    assign cnt_next = stroke_cnt + 8'd1;

    // Valve pattern for a phase index; reverse direction walks the table backwards.
    function automatic logic [2:0] phase_pattern(input logic [2:0] idx, input logic reverse);
        logic [2:0] i;
        i = reverse ? (3'd5 - idx) : idx;
        case (i)
            3'd0:    phase_pattern = 3'b100;
            3'd1:    phase_pattern = 3'b110;
            3'd2:    phase_pattern = 3'b010;
            3'd3:    phase_pattern = 3'b011;
            3'd4:    phase_pattern = 3'b001;
            3'd5:    phase_pattern = 3'b101;
            default: phase_pattern = 3'b000;
        endcase
    endfunction

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick        <= '0;
            phase       <= '0;
            target      <= '0;
            inlet_valve <= 1'b0;
            pump_valve  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stroke_cnt  <= '0;
`ifdef PUMP_REVERSE_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort takes priority over a simultaneous start
                    if (start && !abort) begin
                        if (strokes != 8'd0) begin
                            state       <= OPEN;
                            target      <= strokes;
                            stroke_cnt  <= '0;
                            tick        <= '0;
                            phase       <= '0;
                            inlet_valve <= 1'b1;
                            busy        <= 1'b1;
`ifdef PUMP_REVERSE_EN
                            dir_q       <= dir;
`endif
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                OPEN: begin
                    if (abort) begin
                        state       <= CLOSE;
                        tick        <= '0;
                        inlet_valve <= 1'b0;
                        pump_valve  <= '0;
                    end else if (tick == SETTLE_LAST) begin
                        state      <= PUMP;
                        tick       <= '0;
                        phase      <= '0;
                        pump_valve <= phase_pattern(3'd0, rev);
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                PUMP: begin
                    if (abort) begin
                        state       <= CLOSE;
                        tick        <= '0;
                        phase       <= '0;
                        inlet_valve <= 1'b0;
                        pump_valve  <= '0;
                    end else if (tick == PHASE_LAST) begin
                        tick <= '0;
                        if (phase == 3'd5) begin
                            stroke_cnt <= cnt_next;
                            phase      <= '0;
                            if (cnt_next == target) begin
                                state       <= CLOSE;
                                inlet_valve <= 1'b0;
                                pump_valve  <= '0;
                            end else begin
                                pump_valve <= phase_pattern(3'd0, rev);
                            end
                        end else begin
                            phase      <= phase + 3'd1;
                            pump_valve <= phase_pattern(phase + 3'd1, rev);
                        end
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                CLOSE: begin
                    if (tick == SETTLE_LAST) begin
                        state <= IDLE;
                        tick  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_source_pump_sequencer.sv
// Self-checking bench for source_pump_sequencer: directed scenarios plus
// randomized dispenses compared against a cycle-indexed timeline model.
// Honours PUMP_REVERSE_EN when defined (drives and models 'dir').
module tb_source_pump_sequencer;

    localparam int P = 2;
    localparam int S = 3;
    localparam logic [2:0] FWD [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       inlet;
        logic [2:0] pv;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] strokes;
    logic       inlet_valve;
    logic [2:0] pump_valve;
    logic       busy;
    logic       done;
    logic [7:0] stroke_cnt;
`ifdef PUMP_REVERSE_EN
    logic       dir = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    source_pump_sequencer #(
        .PHASE_TICKS (P),
        .SETTLE_TICKS(S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
`ifdef PUMP_REVERSE_EN
        .dir        (dir),
`endif
        .strokes    (strokes),
        .inlet_valve(inlet_valve),
        .pump_valve (pump_valve),
        .busy       (busy),
        .done       (done),
        .stroke_cnt (stroke_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Strokes finished by sample t (t = cycles since the start edge, start edge = 1).
    function automatic int strokes_done(int n, int t);
        int k;
        if (t <= S) return 0;
        k = (t - S - 1) / (6 * P);
        return (k > n) ? n : k;
    endfunction

    // Expected outputs at sample t of a dispense of n strokes, aborted at edge ta (0 = none).
    function automatic obs_t expect_at(int n, int ta, int t, bit rev);
        obs_t e;
        int pend, close_start, fin, final_cnt, idx;
        pend        = S + 6 * P * n;
        close_start = (ta != 0) ? ta : pend + 1;
        fin         = close_start + S;
        final_cnt   = (ta != 0) ? strokes_done(n, ta - 1) : n;
        e = '0;
        if (t < close_start) begin
            e.busy  = 1'b1;
            e.inlet = 1'b1;
            e.cnt   = 8'(strokes_done(n, t));
            if (t > S) begin
                idx  = ((t - S - 1) / P) % 6;
                e.pv = FWD[rev ? 5 - idx : idx];
            end
        end else begin
            e.cnt  = 8'(final_cnt);
            e.busy = (t < fin);
            e.done = (t == fin);
        end
        return e;
    endfunction

    task automatic check_obs(input string tag, input obs_t e);
        check({tag, ".busy"},  32'(busy),        32'(e.busy));
        check({tag, ".done"},  32'(done),        32'(e.done));
        check({tag, ".inlet"}, 32'(inlet_valve), 32'(e.inlet));
        check({tag, ".pv"},    32'(pump_valve),  32'(e.pv));
        check({tag, ".cnt"},   32'(stroke_cnt),  32'(e.cnt));
    endtask

    task automatic run_dispense(input string tag, input int n, input int ta, input bit rev);
        int pend, close_start, fin, busy_cycles, dones;
        obs_t e;
        pend        = S + 6 * P * n;
        close_start = (ta != 0) ? ta : pend + 1;
        fin         = close_start + S;
        busy_cycles = 0;
        dones       = 0;
        start   = 1'b1;
        abort   = 1'b0;
        strokes = 8'(n);
`ifdef PUMP_REVERSE_EN
        dir = rev;
`endif
        for (int t = 1; t <= fin; t++) begin
            @(posedge clk); #1;
            check_obs(tag, expect_at(n, ta, t, rev));
            busy_cycles += int'(busy);
            dones       += int'(done);
            // Noise on start/strokes/dir while busy must be ignored; abort only where harmless.
            start   = (t < fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            strokes = 8'($urandom);
            if (t + 1 == ta)
                abort = 1'b1;
            else if (t >= close_start && t < fin)
                abort = 1'($urandom_range(0, 1));
            else
                abort = 1'b0;
`ifdef PUMP_REVERSE_EN
            dir = 1'($urandom_range(0, 1));
`endif
        end
        check({tag, ".busy_len"}, 32'(busy_cycles), 32'(fin - 1));
        check({tag, ".done_cnt"}, 32'(dones), 32'd1);
        // stroke count must hold in IDLE, abort has no effect there
        e = expect_at(n, ta, fin, rev);
        for (int i = 0; i < 3; i++) begin
            abort = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check({tag, ".hold_cnt"},  32'(stroke_cnt), 32'(e.cnt));
            check({tag, ".hold_busy"}, 32'(busy), 32'd0);
            check({tag, ".hold_done"}, 32'(done), 32'd0);
        end
        abort = 1'b0;
    endtask

    initial begin
        obs_t zero;
        int n, ta, pend;
        bit rev;
        logic [7:0] held;
        zero = '0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; strokes = '0;
        repeat (2) @(posedge clk);
        #1;
        check_obs("reset", zero);
        @(negedge clk);
        rst = 1'b0;

        // Nominal two-stroke dispense
        run_dispense("nominal", 2, 0, 1'b0);

        // Zero strokes: immediate done, nothing opens
        held = stroke_cnt;
        start = 1'b1; strokes = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero.done",  32'(done), 32'd1);
        check("zero.busy",  32'(busy), 32'd0);
        check("zero.inlet", 32'(inlet_valve), 32'd0);
        check("zero.pv",    32'(pump_valve), 32'd0);
        check("zero.cnt",   32'(stroke_cnt), 32'(held));
        @(posedge clk); #1;
        check("zero.done2", 32'(done), 32'd0);
        check("zero.busy2", 32'(busy), 32'd0);

        // start and abort together in IDLE: request dropped
        start = 1'b1; abort = 1'b1; strokes = 8'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("both.busy",  32'(busy), 32'd0);
        check("both.done",  32'(done), 32'd0);
        check("both.inlet", 32'(inlet_valve), 32'd0);
        @(posedge clk); #1;
        check("both.busy2", 32'(busy), 32'd0);

        // Abort during stroke 3 phase 2 of a five-stroke dispense
        run_dispense("abort5", 5, S + 2 + 14 * P, 1'b0);

        // Abort while the inlet is still settling
        run_dispense("abort_open", 3, 2, 1'b0);

        // Randomized dispenses
        for (int r = 0; r < 8; r++) begin
            n    = $urandom_range(1, 6);
            pend = S + 6 * P * n;
`ifdef PUMP_REVERSE_EN
            rev = 1'($urandom_range(0, 1));
`else
            rev = 1'b0;
`endif
            ta = 0;
            if ($urandom_range(0, 1) == 1) begin
                ta = $urandom_range(2, pend);
                if (ta > S && (ta - S - 1) % (6 * P) == 0) ta = ta - 1;
            end
            run_dispense("random", n, ta, rev);
        end

`ifdef PUMP_REVERSE_EN
        run_dispense("reverse1", 1, 0, 1'b1);
`endif

        // Reset asserted mid-pump after one completed stroke
        start = 1'b1; strokes = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (S + 6 * P + 2) @(posedge clk);
        #1;
        check("rstmid.pre_cnt",  32'(stroke_cnt), 32'd1);
        check("rstmid.pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_obs("rstmid", zero);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rstmid.no_done", 32'(done), 32'd0);
            check("rstmid.idle",    32'(busy), 32'd0);
        end

        // Normal operation after reset
        run_dispense("post_reset", 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
